// File: rtl/flit_out_stage_arb_pkg.sv
// Shared types and default sizing for the flit output stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package flit_out_stage_arb_pkg;

    localparam int FLIT_WIDTH_DEF   = 64;
    localparam int SYS_DEPTH_DEF    = 4;
    localparam int NORMAL_DEPTH_DEF = 8;
    localparam int STARVE_LIMIT_DEF = 3;

    typedef logic [FLIT_WIDTH_DEF-1:0] flit_t;

    // Which queue the flit currently on the output link came from.
    typedef enum logic {
        SRC_SYS    = 1'b0,
        SRC_NORMAL = 1'b1
    } flit_src_t;

endpackage

// File: rtl/flit_fifo_sync.sv
// Small synchronous FIFO holding generator flits ahead of the output arbiter.
// Latency: a push is visible at dout the following cycle (no fall-through).
// Backpressure: push ignored while full; pop ignored while empty; flush empties it.
// Ports: nocclk/rst clock and sync reset; flush drops all entries; push/din write
// side; pop/dout read side (dout is the current head); full/empty/count status.
module flit_fifo_sync #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       nocclk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = CW'(wr_ptr - rd_ptr);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge nocclk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers alone.
    always_ff @(posedge nocclk) begin
        if (do_push && !rst && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/flit_out_stage_arb.sv
// Buffers system and normal generator flits and merges them onto one output link.
// Latency: one cycle from push into an empty queue to out_flit_valid.
// Backpressure: per-queue ready = !full; the presented flit holds until in_flit_ready.
// Ports: nocclk/rst clock and sync reset; in_sys_* / in_normal_* producer sides with
// out_*_ready; out_flit_valid/out_flit/out_flit_is_system with in_flit_ready to the
// link; in_flush drops everything buffered; out_*_count report queue occupancy.
module flit_out_stage_arb
    import flit_out_stage_arb_pkg::*;
#(
    parameter int FLIT_WIDTH   = FLIT_WIDTH_DEF,
    parameter int SYS_DEPTH    = SYS_DEPTH_DEF,
    parameter int NORMAL_DEPTH = NORMAL_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                              nocclk,
    input  logic                              rst,
    input  logic                              in_sys_flit_valid,
    input  logic [FLIT_WIDTH-1:0]             in_sys_flit,
    output logic                              out_sys_flit_ready,
    input  logic                              in_normal_flit_valid,
    input  logic [FLIT_WIDTH-1:0]             in_normal_flit,
    output logic                              out_normal_flit_ready,
    output logic                              out_flit_valid,
    output logic [FLIT_WIDTH-1:0]             out_flit,
    output logic                              out_flit_is_system,
    input  logic                              in_flit_ready,
    input  logic                              in_flush,
    output logic [$clog2(SYS_DEPTH+1)-1:0]    out_sys_count,
    output logic [$clog2(NORMAL_DEPTH+1)-1:0] out_normal_count
);

    localparam int STW = $clog2(STARVE_LIMIT+1);
    localparam logic [STW-1:0] STARVE_MAX = STW'(STARVE_LIMIT);
    localparam logic [STW-1:0] STARVE_ONE = 1;

    logic [FLIT_WIDTH-1:0] sys_dout;
    logic [FLIT_WIDTH-1:0] normal_dout;
    logic                  sys_full;
    logic                  sys_empty;
    logic                  normal_full;
    logic                  normal_empty;
    logic                  sys_push;
    logic                  normal_push;
    logic                  sys_pop;
    logic                  normal_pop;
    logic                  xfer;

    logic                  lock_valid;
    flit_src_t             lock_src;
    flit_src_t             sel_src;
    logic [STW-1:0]        starve_cnt;

    assign out_sys_flit_ready    = !sys_full;
    assign out_normal_flit_ready = !normal_full;
    assign sys_push              = in_sys_flit_valid && !sys_full;
    assign normal_push           = in_normal_flit_valid && !normal_full;

    flit_fifo_sync #(.WIDTH(FLIT_WIDTH), .DEPTH(SYS_DEPTH)) u_sys_fifo (
        .nocclk (nocclk),
        .rst    (rst),
        .flush  (in_flush),
        .push   (sys_push),
        .din    (in_sys_flit),
        .pop    (sys_pop),
        .dout   (sys_dout),
        .full   (sys_full),
        .empty  (sys_empty),
        .count  (out_sys_count)
    );

    flit_fifo_sync #(.WIDTH(FLIT_WIDTH), .DEPTH(NORMAL_DEPTH)) u_normal_fifo (
        .nocclk (nocclk),
        .rst    (rst),
        .flush  (in_flush),
        .push   (normal_push),
        .din    (in_normal_flit),
        .pop    (normal_pop),
        .dout   (normal_dout),
        .full   (normal_full),
        .empty  (normal_empty),
        .count  (out_normal_count)
    );

    // System wins unless the normal queue has waited through STARVE_LIMIT
    // system grants. A stalled offer keeps its source so the link never sees
    // the flit change underneath it.
    always_comb begin
        sel_src = SRC_SYS;
        if (lock_valid) begin
            sel_src = lock_src;
        end else if (!normal_empty && (sys_empty || starve_cnt == STARVE_MAX)) begin
            sel_src = SRC_NORMAL;
        end
    end

    assign out_flit_valid     = lock_valid || !sys_empty || !normal_empty;
    assign xfer               = out_flit_valid && in_flit_ready;
    assign sys_pop            = xfer && (sel_src == SRC_SYS);
    assign normal_pop         = xfer && (sel_src == SRC_NORMAL);
    assign out_flit_is_system = out_flit_valid && (sel_src == SRC_SYS);
    assign out_flit           = !out_flit_valid ? '0 :
                                (sel_src == SRC_NORMAL) ? normal_dout : sys_dout;

    always_ff @(posedge nocclk) begin
        if (rst || in_flush) begin
            lock_valid <= 1'b0;
            lock_src   <= SRC_SYS;
            starve_cnt <= '0;
        end else begin
            if (xfer) begin
                lock_valid <= 1'b0;
            end else if (out_flit_valid) begin
                lock_valid <= 1'b1;
                lock_src   <= sel_src;
            end

            // Count only system grants that actually overtook a waiting normal flit.
            if (sys_pop) begin
                if (!normal_empty) begin
                    if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + STARVE_ONE;
                end else begin
                    starve_cnt <= '0;
                end
            end else if (normal_pop) begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_flit_out_stage_arb.sv
module tb_flit_out_stage_arb;
    import flit_out_stage_arb_pkg::*;

    localparam int SYS_DEPTH    = 4;
    localparam int NORMAL_DEPTH = 8;
    localparam int STARVE_LIMIT = 3;

    logic        nocclk;
    logic        rst;
    logic        in_sys_flit_valid;
    flit_t       in_sys_flit;
    logic        out_sys_flit_ready;
    logic        in_normal_flit_valid;
    flit_t       in_normal_flit;
    logic        out_normal_flit_ready;
    logic        out_flit_valid;
    flit_t       out_flit;
    logic        out_flit_is_system;
    logic        in_flit_ready;
    logic        in_flush;
    logic [2:0]  out_sys_count;
    logic [3:0]  out_normal_count;

    flit_out_stage_arb #(
        .FLIT_WIDTH(64), .SYS_DEPTH(SYS_DEPTH),
        .NORMAL_DEPTH(NORMAL_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .nocclk               (nocclk),
        .rst                  (rst),
        .in_sys_flit_valid    (in_sys_flit_valid),
        .in_sys_flit          (in_sys_flit),
        .out_sys_flit_ready   (out_sys_flit_ready),
        .in_normal_flit_valid (in_normal_flit_valid),
        .in_normal_flit       (in_normal_flit),
        .out_normal_flit_ready(out_normal_flit_ready),
        .out_flit_valid       (out_flit_valid),
        .out_flit             (out_flit),
        .out_flit_is_system   (out_flit_is_system),
        .in_flit_ready        (in_flit_ready),
        .in_flush             (in_flush),
        .out_sys_count        (out_sys_count),
        .out_normal_count     (out_normal_count)
    );

    initial nocclk = 1'b0;
    always #5 nocclk = ~nocclk;

    int checks = 0;
    int fails  = 0;

    // Reference model: two flit queues plus the arbitration bookkeeping.
    flit_t m_sys_q[$];
    flit_t m_norm_q[$];
    int    m_starve    = 0;
    bit    m_lock      = 0;
    bit    m_lock_norm = 0;

    // Scoreboard of transfers the model predicts, in order.
    flit_t exp_flit[$];
    bit    exp_sys[$];
    bit    grant_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare status against the model, drive inputs,
    // predict the transfer, advance the model, then move past the edge.
    task automatic step(input bit sv, input flit_t sf, input bit nv, input flit_t nf,
                        input bit rdy, input bit fl, input bit rs);
        bit m_valid, m_norm, xfer, sys_acc, norm_acc, had_norm;
        m_valid = m_lock || m_sys_q.size() > 0 || m_norm_q.size() > 0;
        if (m_lock) m_norm = m_lock_norm;
        else        m_norm = m_norm_q.size() > 0 && (m_sys_q.size() == 0 || m_starve == STARVE_LIMIT);

        chk("valid",        out_flit_valid,        m_valid);
        chk("sys_ready",    out_sys_flit_ready,    m_sys_q.size() < SYS_DEPTH);
        chk("normal_ready", out_normal_flit_ready, m_norm_q.size() < NORMAL_DEPTH);
        chk("sys_count",    out_sys_count,         m_sys_q.size());
        chk("normal_count", out_normal_count,      m_norm_q.size());
        if (m_valid) chk("is_system", out_flit_is_system, !m_norm);

        in_sys_flit_valid    = sv;
        in_sys_flit          = sf;
        in_normal_flit_valid = nv;
        in_normal_flit       = nf;
        in_flit_ready        = rdy;
        in_flush             = fl;
        rst                  = rs;

        xfer = m_valid && rdy;
        if (xfer) begin
            grant_log.push_back(!m_norm);
            exp_sys.push_back(!m_norm);
            exp_flit.push_back(m_norm ? m_norm_q[0] : m_sys_q[0]);
        end
        sys_acc  = sv && m_sys_q.size() < SYS_DEPTH;
        norm_acc = nv && m_norm_q.size() < NORMAL_DEPTH;

        if (rs || fl) begin
            m_sys_q.delete();
            m_norm_q.delete();
            m_lock   = 0;
            m_starve = 0;
        end else begin
            if (xfer) begin
                if (m_norm) begin
                    void'(m_norm_q.pop_front());
                    m_starve = 0;
                end else begin
                    had_norm = m_norm_q.size() > 0;
                    void'(m_sys_q.pop_front());
                    m_starve = had_norm ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT) : 0;
                end
                m_lock = 0;
            end else if (m_valid) begin
                m_lock      = 1;
                m_lock_norm = m_norm;
            end
            if (sys_acc)  m_sys_q.push_back(sf);
            if (norm_acc) m_norm_q.push_back(nf);
        end
        @(posedge nocclk);
        #2;
    endtask

    // Monitor: every accepted output must be the next predicted transfer.
    initial begin
        flit_t ef;
        bit    es;
        forever begin
            @(negedge nocclk);
            if (out_flit_valid === 1'b1 && in_flit_ready === 1'b1) begin
                if (exp_flit.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sb_underflow: unexpected flit %h is_system %b at %0t",
                             out_flit, out_flit_is_system, $time);
                end else begin
                    ef = exp_flit.pop_front();
                    es = exp_sys.pop_front();
                    chk("xfer_flit", out_flit, ef);
                    chk("xfer_is_system", out_flit_is_system, es);
                end
            end
        end
    end

    initial begin
        bit    ps, pn, rdy, fl, rs;
        flit_t psf, pnf;
        int    rdy_pct;
        logic [4:0] grants;

        rst = 1'b1;
        in_sys_flit_valid = 0; in_sys_flit = '0;
        in_normal_flit_valid = 0; in_normal_flit = '0;
        in_flit_ready = 0; in_flush = 0;
        repeat (2) @(posedge nocclk);
        #2;

        // Reset state and idle.
        step(0, '0, 0, '0, 0, 0, 0);
        chk("reset_flit", out_flit, 64'h0);
        chk("reset_is_system", out_flit_is_system, 1'b0);
        chk("reset_sys_ready", out_sys_flit_ready, 1'b1);

        // Single system flit: visible next cycle, then transferred.
        step(1, 64'hA5, 0, '0, 1, 0, 0);
        chk("a5_flit", out_flit, 64'hA5);
        chk("a5_is_system", out_flit_is_system, 1'b1);
        step(0, '0, 0, '0, 1, 0, 0);
        step(0, '0, 0, '0, 1, 0, 0);
        chk("a5_count_back", out_sys_count, 3'd0);

        // Fill the normal queue while the link stalls.
        for (int i = 0; i < NORMAL_DEPTH; i++) step(0, '0, 1, 64'h100 + 64'(i), 0, 0, 0);
        chk("normal_full_ready", out_normal_flit_ready, 1'b0);
        chk("normal_full_count", out_normal_count, 4'd8);
        step(0, '0, 1, 64'h999, 0, 0, 0);
        chk("normal_ninth_count", out_normal_count, 4'd8);
        step(0, '0, 0, '0, 0, 1, 0);

        // Anti-starvation: S,S,S,N,S with a normal flit waiting.
        grant_log.delete();
        step(1, 64'h200, 1, 64'h300, 0, 0, 0);
        step(1, 64'h201, 0, '0, 0, 0, 0);
        step(1, 64'h202, 0, '0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 64'h203 + 64'(i), 0, '0, 1, 0, 0);
        for (int i = 0; i < 5; i++) grants[4-i] = (grant_log.size() > i) ? grant_log[i] : 1'bx;
        chk("starve_order", grants, 5'b11101);
        repeat (8) step(0, '0, 0, '0, 1, 0, 0);

        // Held system flit stays put when a normal flit shows up.
        step(1, 64'h11, 0, '0, 0, 0, 0);
        repeat (3) step(0, '0, 0, '0, 0, 0, 0);
        step(0, '0, 1, 64'h22, 0, 0, 0);
        step(0, '0, 0, '0, 0, 0, 0);
        chk("hold_flit", out_flit, 64'h11);
        chk("hold_is_system", out_flit_is_system, 1'b1);
        step(0, '0, 0, '0, 1, 0, 0);
        chk("after_hold_flit", out_flit, 64'h22);
        chk("after_hold_is_system", out_flit_is_system, 1'b0);
        repeat (2) step(0, '0, 0, '0, 1, 0, 0);

        // Flush with a concurrent push.
        for (int i = 0; i < 3; i++) step(1, 64'h31 + 64'(i), 1, 64'h41 + 64'(i), 0, 0, 0);
        chk("preflush_sys_count", out_sys_count, 3'd3);
        chk("preflush_normal_count", out_normal_count, 4'd3);
        step(1, 64'h77, 1, 64'h88, 0, 1, 0);
        chk("flush_sys_count", out_sys_count, 3'd0);
        chk("flush_normal_count", out_normal_count, 4'd0);
        chk("flush_valid", out_flit_valid, 1'b0);
        repeat (3) step(0, '0, 0, '0, 1, 0, 0);

        // Randomized traffic with varying link pressure, flushes and resets.
        ps = 0; pn = 0; psf = '0; pnf = '0;
        for (int blk = 0; blk < 6; blk++) begin
            rdy_pct = (blk % 3 == 0) ? 30 : (blk % 3 == 1) ? 70 : 95;
            for (int c = 0; c < 300; c++) begin
                bit sacc, nacc;
                if (!ps && $urandom_range(0, 1) == 1) begin ps = 1; psf = {$urandom, $urandom}; end
                if (!pn && $urandom_range(0, 1) == 1) begin pn = 1; pnf = {$urandom, $urandom}; end
                rdy = $urandom_range(0, 99) < rdy_pct;
                fl  = $urandom_range(0, 63) == 0;
                rs  = $urandom_range(0, 199) == 0;
                sacc = ps && m_sys_q.size() < SYS_DEPTH;
                nacc = pn && m_norm_q.size() < NORMAL_DEPTH;
                step(ps, psf, pn, pnf, rdy, fl, rs);
                if (sacc) ps = 0;
                if (nacc) pn = 0;
            end
        end

        repeat (20) step(0, '0, 0, '0, 1, 0, 0);
        @(negedge nocclk);
        #1;
        chk("scoreboard_drained", exp_flit.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
